uart_tx_engine: RTL and testbench

Parametrised UART transmitter combining a character queue, a baud-rate generator, and a frame-sequencing FSM into one block. It supports run-time character length, parity mode, stop-bit count and bit period, and issues back-to-back frames without idle gaps. It sits between the memory-mapped UART register file, which pushes characters and drives configuration, and the `tx` pad.

---
 rtl/uart_pkg.sv | 44 ++++
 rtl/fifo.sv | 61 ++++++
 rtl/uart_tx_engine.sv | 151 +++++++++++++++
 tb/tb_uart_tx_engine.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: transmitter state encoding, parity modes, per-frame configuration.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package uart_pkg;

    // Character-length field width in the frame configuration (supports characters up to 16 bits).
    localparam int UART_LEN_W = 4;

    // Transmitter FSM encodings, kept as plain constants so older code can compare against them.
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    typedef enum logic [2:0] {
        TX_IDLE   = ST_IDLE,
        TX_START  = ST_START,
        TX_DATA   = ST_DATA,
        TX_PARITY = ST_PARITY,
        TX_STOP1  = ST_STOP1,
        TX_STOP2  = ST_STOP2
    } uart_tx_state_e;

    // 2'b01 is also treated as "no parity": only bit 1 enables the parity bit.
    typedef enum logic [1:0] {
        PARITY_NONE = 2'b00,
        PARITY_EVEN = 2'b10,
        PARITY_ODD  = 2'b11
    } uart_parity_e;

    typedef struct packed {
        logic [UART_LEN_W-1:0] char_len;     // data bits minus one
        logic [1:0]            parity_type;
        logic                  double_stop;
    } uart_cfg_t;

    // Character lengths below 5 bits are not supported on the line; round them up to 5.
    function automatic logic [UART_LEN_W-1:0] uart_clamp_len(input logic [UART_LEN_W-1:0] len_m1);
        return (len_m1 < 4'd4) ? 4'd4 : len_m1;
    endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO with show-ahead read data and an occupancy counter.
// Latency: a push is visible on empty/level/rd_data the cycle after the write edge.
// Backpressure: pushes while full are ignored unless a pop happens in the same cycle.
//
// Ports: clk, reset (async active-low); wr_en/wr_data push; rd_en pop with rd_data
// showing the head entry; full, empty and level report occupancy.
module fifo #(
    parameter int XLEN   = 8,
    parameter int LENGTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wr_en,
    input  logic [XLEN-1:0]           wr_data,
    input  logic                      rd_en,
    output logic [XLEN-1:0]           rd_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(LENGTH):0]   level
);

    localparam int AW = $clog2(LENGTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(LENGTH);

    logic [XLEN-1:0] mem [LENGTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     cnt_q;
    logic            do_push;
    logic            do_pop;

    assign full    = (cnt_q == DEPTH);
    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign rd_data = mem[rd_ptr];

    // A full queue can still take a write when the head leaves in the same cycle.
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmitter: character queue, baud counter and frame FSM driving the tx pad.
// Latency: write into an empty idle queue -> tx low two edges later; frames run back to back.
// Backpressure: writes into a full queue are dropped (overflow pulse) unless a pop coincides.
//
// Ports: clk, reset (async active-low); tx_enable, divisor, char_len, parity_type,
// double_stop configure framing (latched per frame); wr_en/wr_data push characters;
// tx serial line; busy; queue_full/queue_empty/queue_level; overflow and idle_irq pulses.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int TX_QUEUE_SIZE = 16,
    parameter int DIVISOR_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tx_enable,
    input  logic [DIVISOR_WIDTH-1:0]         divisor,
    input  logic [$clog2(DATA_WIDTH)-1:0]    char_len,
    input  logic [1:0]                       parity_type,
    input  logic                             double_stop,
    input  logic                             wr_en,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    output logic                             tx,
    output logic                             busy,
    output logic                             queue_full,
    output logic                             queue_empty,
    output logic [$clog2(TX_QUEUE_SIZE):0]   queue_level,
    output logic                             overflow,
    output logic                             idle_irq
);

    logic [2:0]               state_q;
    logic [2:0]               state_d;
    logic [DIVISOR_WIDTH-1:0] cnt_q;
    logic [DIVISOR_WIDTH-1:0] div_q;
    uart_cfg_t                cfg_q;
    uart_cfg_t                cfg_new;
    logic [DATA_WIDTH-1:0]    shift_q;
    logic [DATA_WIDTH-1:0]    q_rd_dat;
    logic [UART_LEN_W-1:0]    bit_idx_q;
    logic                     parity_q;
    logic                     tx_q;
    logic                     overflow_q;
    logic                     line_d;
    logic                     bit_done;
    logic                     last_stop;
    logic                     start_ok;
    logic                     pop;

    fifo #(
        .XLEN   (DATA_WIDTH),
        .LENGTH (TX_QUEUE_SIZE)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (q_rd_dat),
        .full    (queue_full),
        .empty   (queue_empty),
        .level   (queue_level)
    );

    assign cfg_new.char_len    = uart_clamp_len(UART_LEN_W'(char_len));
    assign cfg_new.parity_type = parity_type;
    assign cfg_new.double_stop = double_stop;

    assign bit_done  = (cnt_q == div_q);
    assign start_ok  = tx_enable && !queue_empty;
    assign last_stop = bit_done &&
                       ((state_q == ST_STOP1 && !cfg_q.double_stop) || state_q == ST_STOP2);

    // A new frame is popped either from idle or on the final cycle of the previous frame,
    // so consecutive characters leave no idle bit between STOP and START.
    assign pop      = start_ok && (state_q == ST_IDLE || last_stop);
    assign idle_irq = last_stop && queue_empty;
    assign busy     = (state_q != ST_IDLE);
    assign tx       = tx_q;
    assign overflow = overflow_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok) state_d = ST_START;
            ST_START:  if (bit_done) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_done && bit_idx_q == cfg_q.char_len)
                    state_d = cfg_q.parity_type[1] ? ST_PARITY : ST_STOP1;
            end
            ST_PARITY: if (bit_done) state_d = ST_STOP1;
            ST_STOP1: begin
                if (bit_done) begin
                    if (cfg_q.double_stop) state_d = ST_STOP2;
                    else                   state_d = start_ok ? ST_START : ST_IDLE;
                end
            end
            ST_STOP2:  if (bit_done) state_d = start_ok ? ST_START : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Line level for the current state; registered into tx, so the pad trails the FSM by one cycle.
    always_comb begin
        line_d = 1'b1;
        case (state_q)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_q[0];
            ST_PARITY: line_d = parity_q;
            default:   line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            cfg_q      <= '0;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_q       <= line_d;
            overflow_q <= wr_en && queue_full && !pop;

            // Every state change coincides with bit_done, so this also reloads on state entry.
            if (state_q == ST_IDLE || bit_done) cnt_q <= '0;
            else                                cnt_q <= cnt_q + 1'b1;

            // START seeds the accumulator from the latched mode: odd parity starts at 1.
            if (state_q == ST_START) parity_q <= cfg_q.parity_type[0];

            if (pop) begin
                shift_q   <= q_rd_dat;
                div_q     <= divisor;
                cfg_q     <= cfg_new;
                bit_idx_q <= '0;
            end else if (state_q == ST_DATA && bit_done) begin
                shift_q   <= shift_q >> 1;
                parity_q  <= parity_q ^ shift_q[0];
                bit_idx_q <= bit_idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: frame table plus back-to-back, config, overflow and reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_enable = 1'b0;
    logic [15:0] divisor = 16'd3;
    logic [2:0]  char_len = 3'd7;
    logic [1:0]  parity_type = 2'b00;
    logic        double_stop = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        tx;
    logic        busy;
    logic        queue_full;
    logic        queue_empty;
    logic [4:0]  queue_level;
    logic        overflow;
    logic        idle_irq;

    uart_tx_engine #(
        .DATA_WIDTH    (8),
        .TX_QUEUE_SIZE (16),
        .DIVISOR_WIDTH (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_enable   (tx_enable),
        .divisor     (divisor),
        .char_len    (char_len),
        .parity_type (parity_type),
        .double_stop (double_stop),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .tx          (tx),
        .busy        (busy),
        .queue_full  (queue_full),
        .queue_empty (queue_empty),
        .queue_level (queue_level),
        .overflow    (overflow),
        .idle_irq    (idle_irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Event counters sampled on the falling edge.
    int busy_cnt = 0;
    int irq_cnt = 0;
    int ovf_cnt = 0;
    int txlow_cnt = 0;
    always @(negedge clk) begin
        if (busy)     busy_cnt++;
        if (idle_irq) irq_cnt++;
        if (overflow) ovf_cnt++;
        if (!tx)      txlow_cnt++;
    end

    typedef struct {
        logic [15:0] div;
        logic [2:0]  clen;
        logic [1:0]  par;
        logic        ds;
        logic [7:0]  data;
        int          nbits;    // line bits including start/parity/stop
        logic [15:0] pattern;  // bit j = j-th line bit
        int          frame;    // expected busy cycles
    } vec_t;

    vec_t vt[5];

    logic seg_bit[$];
    int   seg_len[$];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // Each queued segment is one comparison: tx must hold the bit for all of its cycles.
    task automatic check_stream(input string nm);
        logic b;
        int   l;
        int   bad;
        int   idx;
        idx = 0;
        while (seg_bit.size() > 0) begin
            b = seg_bit.pop_front();
            l = seg_len.pop_front();
            bad = 0;
            for (int c = 0; c < l; c++) begin
                @(negedge clk);
                if (tx !== b) bad++;
            end
            n_vec++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL %s bit%0d: tx wrong on %0d of %0d cycles, expected %b", nm, idx, bad, l, b);
            end
            idx++;
        end
    endtask

    task automatic add_frame(input logic [7:0] d, input int nd, input logic par_en,
                             input logic odd, input int stops, input int len);
        logic p;
        p = odd;
        seg_bit.push_back(1'b0); seg_len.push_back(len);
        for (int j = 0; j < nd; j++) begin
            seg_bit.push_back(d[j]); seg_len.push_back(len);
            p = p ^ d[j];
        end
        if (par_en) begin seg_bit.push_back(p); seg_len.push_back(len); end
        for (int j = 0; j < stops; j++) begin seg_bit.push_back(1'b1); seg_len.push_back(len); end
    endtask

    task automatic wait_busy(input string nm);
        int n;
        n = 0;
        while (!busy && n < 8) begin @(negedge clk); n++; end
        n_vec++;
        if (!busy) begin
            n_err++;
            $display("FAIL %s: busy never rose within %0d cycles", nm, n);
        end
    endtask

    task automatic run_vec(input int i);
        int b0;
        int i0;
        @(negedge clk);
        divisor = vt[i].div; char_len = vt[i].clen; parity_type = vt[i].par;
        double_stop = vt[i].ds; tx_enable = 1'b1; wr_data = vt[i].data; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        check($sformatf("v%0d empty_after_write", i), 32'(queue_empty), 0);
        b0 = busy_cnt; i0 = irq_cnt;
        @(negedge clk);
        check($sformatf("v%0d tx_high_before_start", i), 32'(tx), 1);
        check($sformatf("v%0d popped", i), 32'(queue_empty), 1);
        for (int j = 0; j < vt[i].nbits; j++) begin
            seg_bit.push_back(vt[i].pattern[j]);
            seg_len.push_back(int'(vt[i].div) + 1);
        end
        check_stream($sformatf("v%0d", i));
        repeat (2) @(negedge clk);
        check($sformatf("v%0d frame_len", i), busy_cnt - b0, vt[i].frame);
        check($sformatf("v%0d idle_irq_cnt", i), irq_cnt - i0, 1);
        check($sformatf("v%0d idle_after", i), 32'(busy), 0);
    endtask

    initial begin
        int b0;
        int i0;
        int o0;
        int t0;

        vt[0] = '{16'd3, 3'd7, 2'b00, 1'b0, 8'h55, 10, 16'h02AA, 40};  // 8N1
        vt[1] = '{16'd1, 3'd6, 2'b10, 1'b1, 8'h03, 11, 16'h0606, 22};  // 7E2
        vt[2] = '{16'd1, 3'd6, 2'b11, 1'b0, 8'h03, 10, 16'h0306, 20};  // 7O1
        vt[3] = '{16'd0, 3'd2, 2'b11, 1'b0, 8'hFF,  8, 16'h00BE,  8};  // len clamps to 5, O1, div 0
        vt[4] = '{16'd2, 3'd5, 2'b10, 1'b0, 8'h2D,  9, 16'h015A, 27};  // 6E1

        // Reset state
        #1 reset = 1'b0;
        #2;
        check("rst tx", 32'(tx), 1);
        check("rst busy", 32'(busy), 0);
        check("rst empty", 32'(queue_empty), 1);
        check("rst full", 32'(queue_full), 0);
        check("rst level", 32'(queue_level), 0);
        check("rst overflow", 32'(overflow), 0);
        check("rst idle_irq", 32'(idle_irq), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(i);

        // Back-to-back 8N1 frames
        @(negedge clk);
        tx_enable = 1'b0; divisor = 16'd1; char_len = 3'd7; parity_type = 2'b00; double_stop = 1'b0;
        wr_en = 1'b1; wr_data = 8'hA1;
        @(negedge clk); wr_data = 8'hB2;
        @(negedge clk); wr_data = 8'hC3;
        @(negedge clk); wr_en = 1'b0;
        check("b2b level3", 32'(queue_level), 3);
        b0 = busy_cnt; i0 = irq_cnt;
        tx_enable = 1'b1;
        wait_busy("b2b start");
        add_frame(8'hA1, 8, 1'b0, 1'b0, 1, 2);
        add_frame(8'hB2, 8, 1'b0, 1'b0, 1, 2);
        add_frame(8'hC3, 8, 1'b0, 1'b0, 1, 2);
        fork
            check_stream("b2b");
            begin
                check("b2b level2", 32'(queue_level), 2);
                repeat (20) @(negedge clk);
                check("b2b level1", 32'(queue_level), 1);
                repeat (20) @(negedge clk);
                check("b2b level0", 32'(queue_level), 0);
            end
        join
        repeat (2) @(negedge clk);
        check("b2b busy_cycles", busy_cnt - b0, 60);
        check("b2b idle_irq_cnt", irq_cnt - i0, 1);

        // Mid-frame configuration change
        @(negedge clk);
        tx_enable = 1'b0; divisor = 16'd3; char_len = 3'd7;
        wr_en = 1'b1; wr_data = 8'h0F;
        @(negedge clk); wr_data = 8'hF0;
        @(negedge clk); wr_en = 1'b0;
        b0 = busy_cnt; i0 = irq_cnt;
        tx_enable = 1'b1;
        wait_busy("cfg start");
        add_frame(8'h0F, 8, 1'b0, 1'b0, 1, 4);
        add_frame(8'hF0, 7, 1'b0, 1'b0, 1, 8);
        fork
            check_stream("cfg");
            begin
                repeat (5) @(negedge clk);
                divisor = 16'd7; char_len = 3'd6;
            end
        join
        repeat (2) @(negedge clk);
        check("cfg busy_cycles", busy_cnt - b0, 112);
        check("cfg idle_irq_cnt", irq_cnt - i0, 1);

        // Overflow, pop+push while full, then reset mid-DATA
        @(negedge clk);
        tx_enable = 1'b0; divisor = 16'd3; char_len = 3'd7; parity_type = 2'b00; double_stop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i * 17);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("fill level", 32'(queue_level), 16);
        check("fill full", 32'(queue_full), 1);
        o0 = ovf_cnt;
        wr_en = 1'b1; wr_data = 8'hEE;
        @(negedge clk);
        wr_en = 1'b0;
        check("ovf pulse", 32'(overflow), 1);
        check("ovf level", 32'(queue_level), 16);
        @(negedge clk);
        check("ovf pulse_end", 32'(overflow), 0);
        check("ovf count", ovf_cnt - o0, 1);
        tx_enable = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        @(negedge clk);
        wr_en = 1'b0;
        check("poppush level", 32'(queue_level), 16);
        check("poppush busy", 32'(busy), 1);
        check("poppush no_ovf", 32'(overflow), 0);
        repeat (10) @(negedge clk);
        check("data bit low", 32'(tx), 0);
        #2 reset = 1'b0;
        #1;
        check("arst tx", 32'(tx), 1);
        check("arst busy", 32'(busy), 0);
        check("arst empty", 32'(queue_empty), 1);
        check("arst level", 32'(queue_level), 0);
        @(negedge clk);
        reset = 1'b1;
        b0 = busy_cnt; t0 = txlow_cnt;
        repeat (20) @(negedge clk);
        check("post_rst no_frame", busy_cnt - b0, 0);
        check("post_rst tx_high", txlow_cnt - t0, 0);
        check("post_rst empty", 32'(queue_empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
